// File: rtl/serial_packet_sender_pkg.sv
// NetworkPkg: types and constants shared by the multi-lane serial sender and its receiver.
// Optional feature macro: SERIAL_SENDER_PARITY_EN
//   defined   -> each lane appends one even-parity bit over its data slice
//   undefined -> frame is syncword + slice only
package NetworkPkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sender_state_t;

  // Link-wide preamble defaults; the receiver hunts for the same pattern.
  localparam int                           DEFAULT_SYNC_BITS = 8;
  localparam logic [DEFAULT_SYNC_BITS-1:0] DEFAULT_SYNCWORD  = 8'hA5;

`ifdef SERIAL_SENDER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Width of the payload slice carried by one lane.
  function automatic int LANE_BITS(input int dataBits, input int lanes);
    return dataBits / lanes;
  endfunction

  // Bits shifted out per lane for one packet: syncword, slice, optional parity.
  function automatic int FRAME_BITS(input int syncBits, input int laneBits);
    return syncBits + laneBits + PARITY_BITS;
  endfunction

endpackage

// File: rtl/serial_packet_sender_lane_shifter.sv
// lane_shifter: one serial lane. Loads syncword + slice (+ parity) and shifts it out MSB first.
// Optional feature macro: SERIAL_SENDER_PARITY_EN (parity bit appended, computed at load time).
module lane_shifter
  import NetworkPkg::*;
#(
  parameter int                   LW        = 16,
  parameter int                   SYNC_BITS = DEFAULT_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNCWORD  = SYNC_BITS'(DEFAULT_SYNCWORD)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [LW-1:0] slice_i,
  output logic          serial_o
);

  localparam int N = FRAME_BITS(SYNC_BITS, LW);

  logic [N-1:0] frame;
  logic [N-1:0] shiftReg_q;
  logic         serial_q;

`ifdef SERIAL_SENDER_PARITY_EN
  assign frame = {SYNCWORD, slice_i, ^slice_i};
`else
  assign frame = {SYNCWORD, slice_i};
`endif

  // Load puts the frame MSB straight on the wire; shift walks the rest out; otherwise drive low.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shiftReg_q <= '0;
      serial_q   <= 1'b0;
    end else if (load_i) begin
      serial_q   <= frame[N-1];
      shiftReg_q <= frame << 1;
    end else if (shift_i) begin
      serial_q   <= shiftReg_q[N-1];
      shiftReg_q <= shiftReg_q << 1;
    end else begin
      serial_q   <= 1'b0;
    end
  end

  assign serial_o = serial_q;

endmodule

// File: rtl/serial_packet_sender.sv
// serial_packet_sender: splits a payload into LANES slices and sends each as syncword + slice,
// MSB first, in lockstep, followed by a forced idle-low gap before the next packet.
// Optional feature macro: SERIAL_SENDER_PARITY_EN (one even-parity bit per lane, N grows by 1).
module serial_packet_sender
  import NetworkPkg::*;
#(
  parameter int                   DATA_BITS  = 32,
  parameter int                   LANES      = 2,
  parameter int                   SYNC_BITS  = DEFAULT_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNCWORD   = SYNC_BITS'(DEFAULT_SYNCWORD),
  parameter int                   GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 send_done,
  output logic [LANES-1:0]     serial_out
);

  localparam int LW = LANE_BITS(DATA_BITS, LANES);
  localparam int N  = FRAME_BITS(SYNC_BITS, LW);

  // The bit counter doubles as the gap counter, so it must cover whichever is longer.
  localparam int CNT_MAX = (GAP_CYCLES > N) ? GAP_CYCLES : N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sender_state_t    state_q;
  logic [CNT_W-1:0] bitCnt_q;
  logic             inReady_q;
  logic             busy_q;
  logic             sendDone_q;

  logic handshake;
  logic shiftEn;

  // inReady_q is only ever high in IDLE, so it alone qualifies the handshake.
  assign handshake = in_valid & inReady_q;
  assign shiftEn   = (state_q == SEND) && (bitCnt_q != LAST_BIT);

  // Sequence IDLE -> SEND -> GAP -> IDLE with every handshake output registered.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      inReady_q  <= 1'b0;
      busy_q     <= 1'b0;
      sendDone_q <= 1'b0;
    end else begin
      sendDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            state_q   <= SEND;
            bitCnt_q  <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            inReady_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        SEND: begin
          if (bitCnt_q == LAST_BIT) begin
            sendDone_q <= 1'b1;
            bitCnt_q   <= '0;
            if (GAP_CYCLES == 0) begin
              state_q   <= IDLE;
              inReady_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end else begin
            bitCnt_q <= bitCnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (bitCnt_q == LAST_GAP) begin
            state_q   <= IDLE;
            inReady_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            bitCnt_q <= bitCnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          bitCnt_q  <= '0;
          inReady_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : gen_lane
    lane_shifter #(
      .LW        (LW),
      .SYNC_BITS (SYNC_BITS),
      .SYNCWORD  (SYNCWORD)
    ) u_lane (
      .clk      (clk),
      .rst_l    (rst_l),
      .load_i   (handshake),
      .shift_i  (shiftEn),
      .slice_i  (data_in[k*LW +: LW]),
      .serial_o (serial_out[k])
    );
  end

  assign in_ready  = inReady_q;
  assign busy      = busy_q;
  assign send_done = sendDone_q;

endmodule
